// File: rtl/gbuff_rd_pkg.sv
// ----------------------------------------------------------------------------
// gbuff_rd_pkg
// Shared definitions for the global-buffer stream reader:
//   rd_state_t  - sequencer states (IDLE, RUN, DRAIN)
//   SKID_DEPTH  - entries in the skid FIFO that absorbs the BRAM read latency
//   SKID_CNT_W  - width of the FIFO occupancy count (holds 0..SKID_DEPTH)
//   OCC_W       - width wide enough for count + in-flight read without overflow
// ----------------------------------------------------------------------------
package gbuff_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W      = SKID_CNT_W + 1;

endpackage

// File: rtl/gbuff_rd_skid.sv
// ----------------------------------------------------------------------------
// gbuff_rd_skid
// Two-entry synchronous FIFO holding BRAM words that the consumer has not yet
// taken. Push and pop may happen in the same cycle. A push into a full FIFO
// or a pop from an empty one is ignored (the reader never issues either).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high flush
//   push       write push_data at the tail
//   push_data  word to store
//   pop        drop the head entry
//   head       current head entry (meaningful when count != 0)
//   count      number of stored entries, 0..SKID_DEPTH
// ----------------------------------------------------------------------------
module gbuff_rd_skid
    import gbuff_rd_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_BITS-1:0]  push_data,
    input  logic                  pop,
    output logic [DATA_BITS-1:0]  head,
    output logic [SKID_CNT_W-1:0] count
);

    // Depth is fixed at two, so single-bit pointers wrap naturally.
    logic [DATA_BITS-1:0]  mem [SKID_DEPTH];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [SKID_CNT_W-1:0] count_q;
    logic                  do_push;
    logic                  do_pop;

    always_comb begin
        do_push = push && (count_q != SKID_CNT_W'(SKID_DEPTH));
        do_pop  = pop && (count_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + SKID_CNT_W'(1);
                2'b01:   count_q <= count_q - SKID_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed through count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/gbuff_stream_reader.sv
// ----------------------------------------------------------------------------
// gbuff_stream_reader
// Read-side sequencer for the global buffer BRAM. A start pulse in IDLE
// captures a base address and word count; the block then issues
// one-cycle-latency reads and presents the returned words as a valid/ready
// stream. A 2-entry skid FIFO plus a bypass of the in-flight word gives one
// word per cycle with no loss under backpressure.
//
// Optional feature (macro GBUFF_RD_STRIDE_EN): adds a stride input captured
// on start; the address advances by stride per read instead of by 1.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       request pulse, sampled only in IDLE
//   base_addr   first word address
//   length      word count, 0..2^ADDR_BITS
//   stride      address increment (GBUFF_RD_STRIDE_EN builds only)
//   busy        transfer in progress
//   done        one-cycle completion pulse
//   ram_en      buffer port enable
//   wr_en       buffer write enable, tied low
//   index       buffer address
//   ram_rdata   buffer read data, valid one cycle after ram_en
//   m_valid     stream word valid
//   m_ready     consumer accepts the word
//   m_data      stream word
//
// Stream handshake: a word transfers on every cycle where m_valid and m_ready
// are both high; once m_valid rises, m_valid and m_data stay unchanged until
// that transfer happens.
// ----------------------------------------------------------------------------
module gbuff_stream_reader
    import gbuff_rd_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
`ifdef GBUFF_RD_STRIDE_EN
    input  logic [ADDR_BITS-1:0] stride,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 ram_en,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] index,
    input  logic [DATA_BITS-1:0] ram_rdata,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data
);

    localparam logic [ADDR_BITS:0] LEN_ONE = (ADDR_BITS + 1)'(1);

    rd_state_t             state;
    rd_state_t             state_next;
    logic                  done_q;
    logic                  done_next;

    logic [ADDR_BITS-1:0]  index_q;
    logic [ADDR_BITS:0]    issue_left;
    logic [ADDR_BITS:0]    beats_left;
    logic                  inflight;
    logic [ADDR_BITS-1:0]  step;

    logic                  accept;
    logic                  issue;
    logic                  pop;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [DATA_BITS-1:0]  fifo_head;
    logic [SKID_CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0]      occupancy;

`ifdef GBUFF_RD_STRIDE_EN
    logic [ADDR_BITS-1:0]  stride_q;
    assign step = stride_q;
`else
    assign step = ADDR_BITS'(1);
`endif

    // ------------------------------------------------------------------
    // Stream side. The word returning from the BRAM this cycle is exposed
    // directly when the FIFO is empty, which gives first data one cycle
    // after the first read. If it is not taken, it is parked in the FIFO,
    // so m_data stays put. With nothing in flight the output is forced
    // to zero so stale BRAM data never leaks.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = (fifo_count == '0);
        m_valid    = !fifo_empty || inflight;
        if (!fifo_empty) begin
            m_data = fifo_head;
        end else if (inflight) begin
            m_data = ram_rdata;
        end else begin
            m_data = '0;
        end
        pop       = m_valid && m_ready;
        fifo_pop  = pop && !fifo_empty;
        fifo_push = inflight && !(fifo_empty && pop);
    end

    // ------------------------------------------------------------------
    // Read issue: a new read is allowed only if, after this cycle's pop,
    // the stored plus in-flight words leave room for it. Counting the pop
    // lets issue resume in the same cycle a full FIFO drains by one.
    // ------------------------------------------------------------------
    always_comb begin
        occupancy = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(pop);
        accept    = (state == ST_IDLE) && start;
        issue     = (state == ST_RUN) && (issue_left != '0)
                    && (occupancy < OCC_W'(SKID_DEPTH));
    end

    // ------------------------------------------------------------------
    // FSM next state and done pulse.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (issue && (issue_left == LEN_ONE)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && (beats_left == LEN_ONE)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Address, issue counter, beat counter and in-flight flag.
    // Clearing inflight on reset discards any BRAM word still returning.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            index_q    <= '0;
            issue_left <= '0;
            beats_left <= '0;
            inflight   <= 1'b0;
`ifdef GBUFF_RD_STRIDE_EN
            stride_q   <= '0;
`endif
        end else begin
            inflight <= issue;
            if (accept) begin
                index_q    <= base_addr;
                issue_left <= length;
                beats_left <= length;
`ifdef GBUFF_RD_STRIDE_EN
                stride_q   <= stride;
`endif
            end else begin
                if (issue) begin
                    index_q    <= index_q + step;
                    issue_left <= issue_left - LEN_ONE;
                end
                if (pop) begin
                    beats_left <= beats_left - LEN_ONE;
                end
            end
        end
    end

    gbuff_rd_skid #(
        .DATA_BITS (DATA_BITS)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (ram_rdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign busy   = (state != ST_IDLE);
    assign done   = done_q;
    assign ram_en = issue;
    assign wr_en  = 1'b0;
    assign index  = index_q;

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_gbuff_stream_reader
// Bench for gbuff_stream_reader with a behavioural one-cycle-latency buffer
// preloaded with word[i] = i+1. Expected addresses and words for each
// transfer are queued up front and consumed as reads and stream transfers
// appear.
// ----------------------------------------------------------------------------
module tb_gbuff_stream_reader;

    localparam int AB = 8;
    localparam int DB = 8;

`ifdef GBUFF_RD_STRIDE_EN
    localparam logic [AB-1:0] STR_A = 8'd3;
    localparam logic [AB-1:0] STR_B = 8'd0;
`else
    localparam logic [AB-1:0] STR_A = 8'd1;
    localparam logic [AB-1:0] STR_B = 8'd1;
`endif

    typedef struct {
        logic [AB-1:0] base;
        logic [AB:0]   len;
        logic [AB-1:0] stride;
        int            mode;      // 0 ready always, 1 fixed pattern, 2 random
        int            exp_done;  // cycle of done pulse, 0 when not fixed
    } vec_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AB-1:0] base_addr;
    logic [AB:0]   length;
    logic [AB-1:0] stride;
    logic          busy;
    logic          done;
    logic          ram_en;
    logic          wr_en;
    logic [AB-1:0] index;
    logic [DB-1:0] ram_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DB-1:0] m_data;

    logic [DB-1:0] mem [256];

    logic [DB-1:0] exp_q[$];
    logic [AB-1:0] idx_q[$];

    int checks;
    int errors;
    int outstanding;
    int ram_en_cnt;
    logic          prev_stall;
    logic [DB-1:0] prev_data;

    bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    vec_t vecs [9];

    gbuff_stream_reader #(
        .ADDR_BITS (AB),
        .DATA_BITS (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef GBUFF_RD_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .wr_en     (wr_en),
        .index     (index),
        .ram_rdata (ram_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
    );

    // clock / buffer model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[index];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},    32'(busy),    0);
        check({tag, "_done"},    32'(done),    0);
        check({tag, "_ram_en"},  32'(ram_en),  0);
        check({tag, "_wr_en"},   32'(wr_en),   0);
        check({tag, "_index"},   32'(index),   0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_data"},  32'(m_data),  0);
    endtask

    // Per-cycle monitor; called at the falling edge.
    task automatic sample_cycle();
        logic pop;
        pop = m_valid && m_ready;
        check("outstanding_le_2", 32'((outstanding + int'(ram_en) - int'(pop)) <= 2), 1);
        check("busy_vs_done", 32'(busy), 32'(!done));
        if (prev_stall) begin
            check("hold_valid", 32'(m_valid), 1);
            check("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (ram_en) begin
            ram_en_cnt++;
            check("wr_en", 32'(wr_en), 0);
            if (idx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_read: got index %0d expected no read", index);
            end else begin
                check("index", 32'(index), 32'(idx_q.pop_front()));
            end
        end
        if (pop) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got %0d expected no word", m_data);
            end else begin
                check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
        outstanding = outstanding + int'(ram_en) - int'(pop);
        prev_stall  = m_valid && !m_ready;
        prev_data   = m_data;
    endtask

    // Driver: one transfer; rst_cyc != 0 asserts reset during that cycle.
    task automatic run_xfer(input vec_t v, input int rst_cyc);
        int            cyc;
        int            done_cyc;
        int            budget;
        logic [AB-1:0] a;
        bit            was_reset;
        exp_q.delete();
        idx_q.delete();
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.base + AB'(i) * v.stride;
            idx_q.push_back(a);
            exp_q.push_back(a + 8'd1);
        end
        outstanding = 0;
        ram_en_cnt  = 0;
        prev_stall  = 1'b0;
        done_cyc    = 0;
        was_reset   = 1'b0;
        budget      = 4 * int'(v.len) + 20;

        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = v.base;
        length    = v.len;
        stride    = v.stride;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc <= budget) begin
            case (v.mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[(cyc - 1) % 8];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (v.mode == 1 && cyc == 3) begin
                start     = 1'b1;
                base_addr = 8'hAA;
                length    = 9'd1;
            end else begin
                start = 1'b0;
            end
            if (cyc == rst_cyc) rst = 1'b1;
            @(negedge clk);
            sample_cycle();
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == rst_cyc) begin
                @(posedge clk); #1;
                rst     = 1'b0;
                m_ready = 1'b0;
                @(negedge clk);
                check_reset_vals("after_rst");
                was_reset = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!was_reset) begin
            if (done_cyc == 0) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done in %0d cycles expected done", budget);
            end
            if (v.exp_done != 0) check("done_cycle", 32'(done_cyc), 32'(v.exp_done));
            check("ram_en_cycles", 32'(ram_en_cnt), 32'(v.len));
            check("words_left", 32'(exp_q.size()), 0);
            check("reads_left", 32'(idx_q.size()), 0);
            @(posedge clk); #1;
            m_ready = 1'b1;
            @(negedge clk);
            check("done_pulse_end", 32'(done), 0);
            check("idle_busy", 32'(busy), 0);
            check("idle_ram_en", 32'(ram_en), 0);
        end
    endtask

    initial begin
        vec_t v;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        stride    = 8'd1;
        m_ready   = 1'b0;
        ram_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = DB'(i + 1);

        vecs[0] = '{base: 8'd4,   len: 9'd5,   stride: 8'd1,  mode: 0, exp_done: 7};
        vecs[1] = '{base: 8'd254, len: 9'd4,   stride: 8'd1,  mode: 0, exp_done: 6};
        vecs[2] = '{base: 8'd0,   len: 9'd0,   stride: 8'd1,  mode: 0, exp_done: 1};
        vecs[3] = '{base: 8'd0,   len: 9'd256, stride: 8'd1,  mode: 0, exp_done: 258};
        vecs[4] = '{base: 8'd10,  len: 9'd8,   stride: 8'd1,  mode: 1, exp_done: 0};
        vecs[5] = '{base: 8'd100, len: 9'd20,  stride: 8'd1,  mode: 2, exp_done: 0};
        vecs[6] = '{base: 8'd255, len: 9'd1,   stride: 8'd1,  mode: 0, exp_done: 3};
        vecs[7] = '{base: 8'd0,   len: 9'd4,   stride: STR_A, mode: 0, exp_done: 6};
        vecs[8] = '{base: 8'd50,  len: 9'd5,   stride: STR_B, mode: 1, exp_done: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
            run_xfer(vecs[k], 0);
        end

        // Reset in cycle 3 of a 10-word run, then a clean run from a new base.
        v = '{base: 8'd20, len: 9'd10, stride: 8'd1, mode: 0, exp_done: 0};
        run_xfer(v, 3);
        v = '{base: 8'd40, len: 9'd6, stride: 8'd1, mode: 0, exp_done: 8};
        run_xfer(v, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
